pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Multi-cycle control FSM that owns the ProgramCounter's en/sr/address inputs.
//  Sequences FETCH/DECODE/EXEC/MEM/WB. Selects next PC: +4, branch target, IRQ vector or restore.
//  Performs one-deep interrupt entry (save return PC) and ERET (restore) via the PC shadow.
// PARAMETERS
//  ADDR_W     32             PC / address width
//  RESET_VEC  32'h0000_0000  PC loaded after reset
//  IRQ_VEC    32'h0000_0080  PC loaded on interrupt entry
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous reset, active-low
//  pc_cur      in   ADDR_W  current PC (ProgramCounter pcout)
//  mem_ready   in   1       memory handshake ack (fetch and data phases)
//  dec_valid   in   1       decoder class valid (sampled in DECODE)
//  dec_class   in   2       00 ALU, 01 MEM, 10 BRANCH/JUMP, 11 ERET
//  br_taken    in   1       branch/jump resolved taken (sampled in EXEC)
//  br_target   in   ADDR_W  branch/jump target
//  irq         in   1       level interrupt request
//  pc_en       out  1       ProgramCounter enable
//  pc_sr       out  2       00 LOAD pc_addr; 01 SAVE (shadow<=pc_addr+4); 11 RESTORE shadow
//  pc_addr     out  ADDR_W  address presented to ProgramCounter
//  fetch_req   out  1       instruction fetch request
//  ir_load     out  1       instruction register load strobe
//  mem_req     out  1       data memory request
//  wb_en       out  1       register-file write strobe
//  in_irq      out  1       handler active (registered)
//  state       out  3       current FSM state (debug)
// BEHAVIOUR
//  States: 0 RST_LD, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB, 6 IRQ_SAVE, 7 IRQ_VEC.
//  Registered: state, latched class (cls), in_irq. Strobes decode from state+inputs (same-cycle).
//  Reset (async): state=RST_LD, in_irq=0, cls=00. Outputs: pc_en=0, pc_sr=00, pc_addr=RESET_VEC.
//   fetch_req/ir_load/mem_req/wb_en=0 while rst_n low.
//  pc_sr=00 and pc_addr=pc_cur whenever pc_en=0 (unless stated).
//  RST_LD: pc_en=1, sr=00, pc_addr=RESET_VEC; -> FETCH.
//  FETCH: fetch_req=1 until mem_ready; ack cycle: ir_load=1, pc_en=1, sr=00.
//   pc_addr=pc_cur+4 mod 2^ADDR_W; -> DECODE.
//  DECODE: hold until dec_valid; cls<=dec_class; -> EXEC.
//  EXEC by cls: ALU -> WB; MEM -> MEM.
//   BRANCH: if br_taken pc_en=1, sr=00, pc_addr=br_target; -> completion.
//   ERET: if in_irq pc_en=1, sr=11, in_irq<=0; else NOP; -> completion.
//  MEM: mem_req=1 until mem_ready; -> WB. WB: wb_en=1 one cycle; -> completion.
//  Completion (end of WB or BRANCH/ERET EXEC): irq && !in_irq -> IRQ_SAVE, else FETCH.
//   ERET completion uses pre-clear in_irq (no re-entry same cycle).
//  IRQ_SAVE: pc_en=1, sr=01, pc_addr=pc_cur-4 (shadow=next PC); -> IRQ_VEC.
//  IRQ_VEC: pc_en=1, sr=00, pc_addr=IRQ_VEC, in_irq<=1; -> FETCH.
//  irq is ignored while in_irq=1 (no nesting); irq is never sampled mid-instruction.
//  mem_ready outside FETCH/MEM is ignored. Request held stable until ack.
//  Wrap: pc_cur=FFFF_FFFC -> +4 = 0. IRQ save at pc_cur=0 -> pc_addr=FFFF_FFFC.
//  Reset mid-operation: state, strobes and in_irq return to reset values immediately.
//   An outstanding request is dropped.
//  Latencies (no wait states): ALU = 4 cycles, MEM = 5, BRANCH/ERET = 3. Each wait adds 1.
// TESTING
//  T1 release rst_n -> 1 cycle pc_en=1,sr=00,addr=0; next cycle fetch_req=1.
//  T2 ALU, pc_cur=0x100, mem_ready after 2 waits -> fetch_req 3 cycles.
//     Ack cycle: pc_en, addr=0x104, ir_load. Then DECODE, EXEC, wb_en, FETCH.
//  T3 BRANCH taken, target 0x200 -> EXEC pc_en=1,sr=00,addr=0x200.
//     Not taken -> pc_en=0. Both -> FETCH.
//  T4 irq=1 during MEM, pc_cur=0x108 at WB -> IRQ_SAVE sr=01,addr=0x104.
//     Then IRQ_VEC addr=0x80, in_irq=1. A second irq is ignored.
//     ERET -> sr=11, in_irq=0.
//  T5 FETCH with pc_cur=0xFFFF_FFFC -> pc_addr=0x0000_0000.
//  T6 rst_n low in MEM with mem_req=1 -> mem_req=0, state=0 without clock edge.
//     After release: RST_LD load of RESET_VEC.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - sequencer control bus: decoder/memory/PC inputs, PC and strobe outputs
interface pc_seq_if #(
   parameter int ADDR_W = 32
) ();
   logic [ADDR_W-1:0] pc_cur;
   logic              mem_ready;
   logic              dec_valid;
   logic [1:0]        dec_class;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;
   logic              irq;
   logic              pc_en;
   logic [1:0]        pc_sr;
   logic [ADDR_W-1:0] pc_addr;
   logic              fetch_req;
   logic              ir_load;
   logic              mem_req;
   logic              wb_en;
   logic              in_irq;
   logic [2:0]        state;

   // sequencer side
   modport master (
      input  pc_cur, mem_ready, dec_valid, dec_class, br_taken, br_target, irq,
      output pc_en, pc_sr, pc_addr, fetch_req, ir_load, mem_req, wb_en, in_irq, state
   );

   // datapath / environment side
   modport slave (
      output pc_cur, mem_ready, dec_valid, dec_class, br_taken, br_target, irq,
      input  pc_en, pc_sr, pc_addr, fetch_req, ir_load, mem_req, wb_en, in_irq, state
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle control FSM driving ProgramCounter en/sr/address
module pc_sequencer #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] IRQ_VEC   = 32'h0000_0080
) (
   input  logic      clk,
   input  logic      rst_n,
   pc_seq_if.master  bus
);

   typedef enum logic [2:0] {
      S_RST_LD   = 3'd0,
      S_FETCH    = 3'd1,
      S_DECODE   = 3'd2,
      S_EXEC     = 3'd3,
      S_MEM      = 3'd4,
      S_WB       = 3'd5,
      S_IRQ_SAVE = 3'd6,
      S_IRQ_VEC  = 3'd7
   } state_t;

   localparam logic [1:0] CLS_ALU  = 2'b00;
   localparam logic [1:0] CLS_MEM  = 2'b01;
   localparam logic [1:0] CLS_BR   = 2'b10;
   localparam logic [1:0] CLS_ERET = 2'b11;

   localparam logic [1:0] SR_LOAD    = 2'b00;
   localparam logic [1:0] SR_SAVE    = 2'b01;
   localparam logic [1:0] SR_RESTORE = 2'b11;

   state_t            state_q, state_d;
   logic [1:0]        cls_q, cls_d;
   logic              in_irq_q, in_irq_d;
   logic              pc_en, fetch_req, ir_load, mem_req, wb_en;
   logic [1:0]        pc_sr;
   logic [ADDR_W-1:0] pc_addr;
   state_t            done_next;

   // state, latched instruction class and handler flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_RST_LD;
         cls_q    <= CLS_ALU;
         in_irq_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cls_q    <= cls_d;
         in_irq_q <= in_irq_d;
      end
   end

   // next state and same-cycle strobes; reset forces quiet outputs without waiting for a clock
   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      in_irq_d  = in_irq_q;
      pc_en     = 1'b0;
      pc_sr     = SR_LOAD;
      pc_addr   = bus.pc_cur;
      fetch_req = 1'b0;
      ir_load   = 1'b0;
      mem_req   = 1'b0;
      wb_en     = 1'b0;
      // completion uses the pre-clear flag so an ERET cannot re-enter in the same cycle
      done_next = (bus.irq && !in_irq_q) ? S_IRQ_SAVE : S_FETCH;
      case (state_q)
         S_RST_LD: begin
            pc_en   = 1'b1;
            pc_addr = RESET_VEC;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            fetch_req = 1'b1;
            if (bus.mem_ready) begin
               ir_load = 1'b1;
               pc_en   = 1'b1;
               pc_addr = bus.pc_cur + ADDR_W'(4);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (bus.dec_valid) begin
               cls_d   = bus.dec_class;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls_q)
               CLS_ALU: state_d = S_WB;
               CLS_MEM: state_d = S_MEM;
               CLS_BR: begin
                  if (bus.br_taken) begin
                     pc_en   = 1'b1;
                     pc_addr = bus.br_target;
                  end
                  state_d = done_next;
               end
               default: begin
                  if (in_irq_q) begin
                     pc_en    = 1'b1;
                     pc_sr    = SR_RESTORE;
                     in_irq_d = 1'b0;
                  end
                  state_d = done_next;
               end
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            if (bus.mem_ready) state_d = S_WB;
         end
         S_WB: begin
            wb_en   = 1'b1;
            state_d = done_next;
         end
         S_IRQ_SAVE: begin
            // shadow captures pc_addr+4, i.e. the current (next-instruction) PC
            pc_en   = 1'b1;
            pc_sr   = SR_SAVE;
            pc_addr = bus.pc_cur - ADDR_W'(4);
            state_d = S_IRQ_VEC;
         end
         default: begin
            pc_en    = 1'b1;
            pc_addr  = IRQ_VEC;
            in_irq_d = 1'b1;
            state_d  = S_FETCH;
         end
      endcase
      if (!rst_n) begin
         pc_en     = 1'b0;
         pc_sr     = SR_LOAD;
         pc_addr   = RESET_VEC;
         fetch_req = 1'b0;
         ir_load   = 1'b0;
         mem_req   = 1'b0;
         wb_en     = 1'b0;
      end
   end

   assign bus.pc_en     = pc_en;
   assign bus.pc_sr     = pc_sr;
   assign bus.pc_addr   = pc_addr;
   assign bus.fetch_req = fetch_req;
   assign bus.ir_load   = ir_load;
   assign bus.mem_req   = mem_req;
   assign bus.wb_en     = wb_en;
   assign bus.in_irq    = in_irq_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

   logic clk = 1'b0;
   logic rst_n;

   pc_seq_if #(.ADDR_W(32)) bus ();

   pc_sequencer #(.ADDR_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [10:0] ctrl;
      logic [31:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, got, want);
      end
   endtask

   // expected control word: {pc_en, pc_sr, fetch_req, ir_load, mem_req, wb_en, in_irq, state}
   function automatic logic [10:0] ex(input logic en, input logic [1:0] sr, input logic fr,
                                      input logic il, input logic mr, input logic wb,
                                      input logic ii, input logic [2:0] st);
      return {en, sr, fr, il, mr, wb, ii, st};
   endfunction

   // compare the expectation queued for this cycle at the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "_ctrl"},
                  {21'd0, bus.pc_en, bus.pc_sr, bus.fetch_req, bus.ir_load, bus.mem_req,
                   bus.wb_en, bus.in_irq, bus.state}, {21'd0, e.ctrl});
            check({e.tag, "_addr"}, bus.pc_addr, e.addr);
         end
      end
   end

   // inputs are set by the caller just after a rising edge; queue what this cycle must show
   task automatic cyc(input string tag, input logic [10:0] ctrl, input logic [31:0] addr);
      exp_t e;
      e.tag  = tag;
      e.ctrl = ctrl;
      e.addr = addr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.mem_ready = 1'b0;
      bus.dec_valid = 1'b0;
      bus.dec_class = 2'b00;
      bus.br_taken  = 1'b0;
      bus.br_target = 32'h0;
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.pc_cur = 32'h0;
      bus.irq    = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1;
      bus.pc_cur = 32'h0000_0040;
      cyc("rst0", ex(0, 0, 0, 0, 0, 0, 0, 0), 32'h0);
      cyc("rst1", ex(0, 0, 0, 0, 0, 0, 0, 0), 32'h0);

      // T1: reset vector load then fetch
      rst_n = 1'b1;
      cyc("t1_ld", ex(1, 0, 0, 0, 0, 0, 0, 0), 32'h0);

      // T2: ALU with two fetch wait states
      bus.pc_cur = 32'h100;
      cyc("t2_w0", ex(0, 0, 1, 0, 0, 0, 0, 1), 32'h100);
      cyc("t2_w1", ex(0, 0, 1, 0, 0, 0, 0, 1), 32'h100);
      bus.mem_ready = 1'b1;
      cyc("t2_ack", ex(1, 0, 1, 1, 0, 0, 0, 1), 32'h104);
      idle_inputs();
      bus.pc_cur = 32'h104; bus.dec_valid = 1'b1; bus.dec_class = 2'b00;
      bus.mem_ready = 1'b1;
      cyc("t2_dec", ex(0, 0, 0, 0, 0, 0, 0, 2), 32'h104);
      idle_inputs();
      cyc("t2_ex", ex(0, 0, 0, 0, 0, 0, 0, 3), 32'h104);
      cyc("t2_wb", ex(0, 0, 0, 0, 0, 1, 0, 5), 32'h104);

      // T3: branch taken, decode held one cycle
      bus.mem_ready = 1'b1;
      cyc("t3_ack", ex(1, 0, 1, 1, 0, 0, 0, 1), 32'h108);
      idle_inputs();
      bus.pc_cur = 32'h108;
      cyc("t3_hold", ex(0, 0, 0, 0, 0, 0, 0, 2), 32'h108);
      bus.dec_valid = 1'b1; bus.dec_class = 2'b10;
      cyc("t3_dec", ex(0, 0, 0, 0, 0, 0, 0, 2), 32'h108);
      idle_inputs();
      bus.br_taken = 1'b1; bus.br_target = 32'h200;
      cyc("t3_tk", ex(1, 0, 0, 0, 0, 0, 0, 3), 32'h200);
      idle_inputs();
      bus.pc_cur = 32'h200; bus.mem_ready = 1'b1;
      cyc("t3_ack2", ex(1, 0, 1, 1, 0, 0, 0, 1), 32'h204);
      idle_inputs();
      bus.pc_cur = 32'h204; bus.dec_valid = 1'b1; bus.dec_class = 2'b10;
      cyc("t3_dec2", ex(0, 0, 0, 0, 0, 0, 0, 2), 32'h204);
      idle_inputs();
      bus.br_target = 32'h300;
      cyc("t3_ntk", ex(0, 0, 0, 0, 0, 0, 0, 3), 32'h204);

      // T4: irq raised during MEM, taken at WB completion
      bus.pc_cur = 32'h104; bus.mem_ready = 1'b1;
      cyc("t4_ack", ex(1, 0, 1, 1, 0, 0, 0, 1), 32'h108);
      idle_inputs();
      bus.pc_cur = 32'h108; bus.dec_valid = 1'b1; bus.dec_class = 2'b01;
      cyc("t4_dec", ex(0, 0, 0, 0, 0, 0, 0, 2), 32'h108);
      idle_inputs();
      cyc("t4_ex", ex(0, 0, 0, 0, 0, 0, 0, 3), 32'h108);
      bus.irq = 1'b1;
      cyc("t4_mw", ex(0, 0, 0, 0, 1, 0, 0, 4), 32'h108);
      bus.mem_ready = 1'b1;
      cyc("t4_mack", ex(0, 0, 0, 0, 1, 0, 0, 4), 32'h108);
      idle_inputs();
      cyc("t4_wb", ex(0, 0, 0, 0, 0, 1, 0, 5), 32'h108);
      cyc("t4_save", ex(1, 1, 0, 0, 0, 0, 0, 6), 32'h104);
      cyc("t4_vec", ex(1, 0, 0, 0, 0, 0, 0, 7), 32'h80);
      bus.pc_cur = 32'h80; bus.mem_ready = 1'b1;
      cyc("t4_hack", ex(1, 0, 1, 1, 0, 0, 1, 1), 32'h84);
      idle_inputs();
      bus.pc_cur = 32'h84; bus.dec_valid = 1'b1;
      cyc("t4_hdec", ex(0, 0, 0, 0, 0, 0, 1, 2), 32'h84);
      idle_inputs();
      cyc("t4_hex", ex(0, 0, 0, 0, 0, 0, 1, 3), 32'h84);
      cyc("t4_hwb", ex(0, 0, 0, 0, 0, 1, 1, 5), 32'h84);
      bus.mem_ready = 1'b1;
      cyc("t4_nonest", ex(1, 0, 1, 1, 0, 0, 1, 1), 32'h88);
      idle_inputs();
      bus.pc_cur = 32'h88; bus.dec_valid = 1'b1; bus.dec_class = 2'b11;
      cyc("t4_edec", ex(0, 0, 0, 0, 0, 0, 1, 2), 32'h88);
      idle_inputs();
      cyc("t4_eret", ex(1, 3, 0, 0, 0, 0, 1, 3), 32'h88);
      bus.irq = 1'b0; bus.pc_cur = 32'h108;
      cyc("t4_after", ex(0, 0, 1, 0, 0, 0, 0, 1), 32'h108);

      // ERET outside a handler is a no-op
      bus.mem_ready = 1'b1;
      cyc("nop_ack", ex(1, 0, 1, 1, 0, 0, 0, 1), 32'h10c);
      idle_inputs();
      bus.pc_cur = 32'h10c; bus.dec_valid = 1'b1; bus.dec_class = 2'b11;
      cyc("nop_dec", ex(0, 0, 0, 0, 0, 0, 0, 2), 32'h10c);
      idle_inputs();
      cyc("nop_eret", ex(0, 0, 0, 0, 0, 0, 0, 3), 32'h10c);

      // T5: fetch at top of address space wraps to zero
      bus.pc_cur = 32'hFFFF_FFFC; bus.mem_ready = 1'b1;
      cyc("t5_wrap", ex(1, 0, 1, 1, 0, 0, 0, 1), 32'h0);
      idle_inputs();

      // T6: reset asserted mid-MEM drops the request without a clock edge
      bus.pc_cur = 32'h0; bus.dec_valid = 1'b1; bus.dec_class = 2'b01;
      cyc("t6_dec", ex(0, 0, 0, 0, 0, 0, 0, 2), 32'h0);
      idle_inputs();
      cyc("t6_ex", ex(0, 0, 0, 0, 0, 0, 0, 3), 32'h0);
      check("t6_pre_memreq", {31'd0, bus.mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_memreq", {31'd0, bus.mem_req}, 32'd0);
      check("t6_state", {29'd0, bus.state}, 32'd0);
      cyc("t6_rst", ex(0, 0, 0, 0, 0, 0, 0, 0), 32'h0);
      rst_n = 1'b1;
      bus.pc_cur = 32'h0000_0500;
      cyc("t6_ld", ex(1, 0, 0, 0, 0, 0, 0, 0), 32'h0);
      cyc("t6_fetch", ex(0, 0, 1, 0, 0, 0, 0, 1), 32'h500);

      // IRQ save at pc_cur=0 wraps backwards
      bus.irq = 1'b1; bus.mem_ready = 1'b1;
      cyc("w_ack", ex(1, 0, 1, 1, 0, 0, 0, 1), 32'h504);
      idle_inputs();
      bus.dec_valid = 1'b1; bus.dec_class = 2'b10;
      cyc("w_dec", ex(0, 0, 0, 0, 0, 0, 0, 2), 32'h500);
      idle_inputs();
      cyc("w_ex", ex(0, 0, 0, 0, 0, 0, 0, 3), 32'h500);
      bus.pc_cur = 32'h0;
      cyc("w_save", ex(1, 1, 0, 0, 0, 0, 0, 6), 32'hFFFF_FFFC);
      bus.irq = 1'b0;
      cyc("w_vec", ex(1, 0, 0, 0, 0, 0, 0, 7), 32'h80);
      cyc("w_in", ex(0, 0, 1, 0, 0, 0, 1, 1), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
